// File: rtl/rv32i_writeback_if.sv
// Writeback-stage interface: ALU results, load issue and load responses in,
// register-file write port and hazard status out.
// Optional forwarding taps exist only when RV32I_WB_FWD_EN is defined.
interface rv32i_writeback_if #(
    parameter int LOG2_REGFILE_ENTRIES = 5
);
    localparam int NREG = 1 << LOG2_REGFILE_ENTRIES;

    logic                            alu_valid;
    logic [LOG2_REGFILE_ENTRIES-1:0] alu_rd_idx;
    logic [31:0]                     alu_result;
    logic                            ld_req;
    logic [LOG2_REGFILE_ENTRIES-1:0] ld_rd_idx;
    logic [2:0]                      ld_funct3;
    logic [1:0]                      ld_byte_off;
    logic                            rdata_valid;
    logic [31:0]                     rdata;
    logic [LOG2_REGFILE_ENTRIES-1:0] rd_idx;
    logic [31:0]                     new_rd;
    logic                            stall;
    logic [NREG-1:0]                 pending;
    logic                            ld_full;
    logic                            rsp_err;
`ifdef RV32I_WB_FWD_EN
    logic [LOG2_REGFILE_ENTRIES-1:0] fwd_idx;
    logic [31:0]                     fwd_data;
`endif

    // Upstream pipeline / memory side
    modport master (
`ifdef RV32I_WB_FWD_EN
        input  fwd_idx, fwd_data,
`endif
        output alu_valid, alu_rd_idx, alu_result,
        output ld_req, ld_rd_idx, ld_funct3, ld_byte_off,
        output rdata_valid, rdata,
        input  rd_idx, new_rd, stall, pending, ld_full, rsp_err
    );

    // Writeback block side
    modport slave (
`ifdef RV32I_WB_FWD_EN
        output fwd_idx, fwd_data,
`endif
        input  alu_valid, alu_rd_idx, alu_result,
        input  ld_req, ld_rd_idx, ld_funct3, ld_byte_off,
        input  rdata_valid, rdata,
        output rd_idx, new_rd, stall, pending, ld_full, rsp_err
    );
endinterface

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: in-order load queue, load alignment/extension,
// single registered register-file write per cycle (load > skid > ALU),
// pending-load scoreboard and upstream stall generation.
// Optional: define RV32I_WB_FWD_EN to expose the pre-register winner as
// fwd_idx/fwd_data for same-cycle bypass in decode.
module rv32i_writeback #(
    parameter int LOG2_REGFILE_ENTRIES = 5,
    parameter int LOG2_LD_DEPTH        = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    rv32i_writeback_if.slave   wb
);
    localparam int NREG  = 1 << LOG2_REGFILE_ENTRIES;
    localparam int DEPTH = 1 << LOG2_LD_DEPTH;
    localparam int IW    = LOG2_REGFILE_ENTRIES;
    localparam int PW    = LOG2_LD_DEPTH;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [2:0]    funct3;
        logic [1:0]    off;
    } ld_ent_t;

    ld_ent_t       q_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, full, push, pop;
    ld_ent_t       head;
    logic          head_shared;
    logic [31:0]   ld_data;

    logic          stall, alu_acc, alu_wr;
    logic          skid_full;
    logic [IW-1:0] skid_idx;
    logic [31:0]   skid_data;

    logic          win_v;
    logic [IW-1:0] win_idx;
    logic [31:0]   win_data;

    logic [NREG-1:0] pending_q;
    logic [IW-1:0]   rd_idx_q;
    logic [31:0]     new_rd_q;
    logic            rsp_err_q;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign head  = q_mem[rd_ptr];

    // Hazard stall: skid occupied, load queue cannot take the new load,
    // or an ALU write would race an outstanding load to the same register.
    always_comb begin
        stall = skid_full
              | (wb.ld_req & full & ~wb.rdata_valid)
              | (wb.alu_valid & (wb.alu_rd_idx != '0) & pending_q[wb.alu_rd_idx]);
    end

    // A held (stalled) load is re-presented, so only count it once accepted.
    assign push    = wb.ld_req & ~stall;
    assign pop     = wb.rdata_valid & ~empty;
    assign alu_acc = wb.alu_valid & ~stall;
    assign alu_wr  = alu_acc & (wb.alu_rd_idx != '0);

    // Does any queued entry behind the head target the head's register?
    always_comb begin
        head_shared = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if ((PW+1)'(k) < count &&
                q_mem[rd_ptr + PW'(k)].idx == head.idx)
                head_shared = 1'b1;
        end
    end

    // Align and extend the response word according to the head entry.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = wb.rdata[8*head.off +: 8];
        h = head.off[1] ? wb.rdata[31:16] : wb.rdata[15:0];
        case (head.funct3)
            3'b000:  ld_data = {{24{b[7]}}, b};
            3'b100:  ld_data = {24'd0, b};
            3'b001:  ld_data = {{16{h[15]}}, h};
            3'b101:  ld_data = {16'd0, h};
            default: ld_data = wb.rdata;
        endcase
    end

    // Write arbitration: load response, then skid entry, then fresh ALU result.
    always_comb begin
        win_v    = 1'b0;
        win_idx  = '0;
        win_data = '0;
        if (pop) begin
            win_v    = 1'b1;
            win_idx  = head.idx;
            win_data = ld_data;
        end else if (skid_full) begin
            win_v    = 1'b1;
            win_idx  = skid_idx;
            win_data = skid_data;
        end else if (alu_wr) begin
            win_v    = 1'b1;
            win_idx  = wb.alu_rd_idx;
            win_data = wb.alu_result;
        end
    end

    // Queue storage; contents are qualified by count so no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= '{idx: wb.ld_rd_idx, funct3: wb.ld_funct3, off: wb.ld_byte_off};
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Scoreboard: set on push, clear on pop unless still targeted; set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            logic [NREG-1:0] nxt;
            nxt = pending_q;
            if (pop && head.idx != '0 && !head_shared)
                nxt[head.idx] = 1'b0;
            if (push && wb.ld_rd_idx != '0)
                nxt[wb.ld_rd_idx] = 1'b1;
            pending_q <= nxt;
        end
    end

    // Skid holds an ALU result that lost to a simultaneous load response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_full <= 1'b0;
            skid_idx  <= '0;
            skid_data <= '0;
        end else if (pop && alu_wr) begin
            skid_full <= 1'b1;
            skid_idx  <= wb.alu_rd_idx;
            skid_data <= wb.alu_result;
        end else if (!pop && skid_full) begin
            skid_full <= 1'b0;
        end
    end

    // Registered write port and sticky spurious-response flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx_q  <= '0;
            new_rd_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rd_idx_q <= win_v ? win_idx : '0;
            if (win_v)
                new_rd_q <= win_data;
            if (wb.rdata_valid && empty)
                rsp_err_q <= 1'b1;
        end
    end

    assign wb.rd_idx  = rd_idx_q;
    assign wb.new_rd  = new_rd_q;
    assign wb.stall   = stall;
    assign wb.pending = pending_q;
    assign wb.ld_full = full;
    assign wb.rsp_err = rsp_err_q;

`ifdef RV32I_WB_FWD_EN
    assign wb.fwd_idx  = win_v ? win_idx : '0;
    assign wb.fwd_data = win_data;
`endif

endmodule
